leb128_fetch: RTL and testbench

Immediate-operand fetch stage between `genrom` and the `cpu` execute logic. On request it reads a byte window at a given program counter, decodes one WebAssembly LEB128 immediate (unsigned or signed, 32- or 64-bit) byte-serially, and returns the value, its encoded length and the next program counter. Malformed encodings and ROM bound violations are reported as trap codes that the CPU forwards unchanged to its `trap` output.

---
 rtl/leb128_fetch_pkg.sv | 48 ++++
 rtl/leb128_fetch.sv | 196 +++++++++++++++++++
 tb/tb_leb128_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/leb128_fetch_pkg.sv
// Shared type codes, trap codes, FSM encoding and LEB128 helper functions
// for the immediate-operand fetch stage.
package leb128_fetch_pkg;

    // Operand type codes shared with the CPU execute logic.
    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;

    // Trap codes forwarded unchanged by the CPU; zero means no trap.
    localparam logic [3:0] TRAP_NONE         = 4'd0;
    localparam logic [3:0] TRAP_MEM_BOUNDS   = 4'd1;
    localparam logic [3:0] TRAP_LEB_OVERLONG = 4'd2;
    localparam logic [3:0] TRAP_LEB_PADDING  = 4'd3;

    // Longest encoding is 10 bytes, so only 80 bits of the ROM window matter.
    localparam int WIN_BITS = 80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Ones in every bit at or above 7*len; len must be 1..9 so the shift stays below 64.
    function automatic logic [63:0] sign_fill_mask(input logic [3:0] len);
        logic [6:0] sh;
        sh = 7'(len) * 7'd7;
        return ~((64'd1 << sh) - 64'd1);
    endfunction

    // Checks the unused high payload bits of a maximum-length final byte.
    function automatic logic pad_ok(input logic [6:0] payload,
                                    input logic       wide,
                                    input logic       sgn);
        logic ok;
        case ({wide, sgn})
            2'b00:   ok = (payload[6:4] == 3'b000);
            2'b01:   ok = (payload[6:3] == 4'b0000) || (payload[6:3] == 4'b1111);
            2'b10:   ok = (payload[6:1] == 6'b000000);
            2'b11:   ok = (payload[6:0] == 7'b0000000) || (payload[6:0] == 7'b1111111);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/leb128_fetch.sv
// LEB128 immediate fetch: reads a ROM window at pc, decodes one signed or
// unsigned 32/64-bit LEB128 value byte-serially and reports value, length,
// next pc and trap code with a one-cycle done pulse.
module leb128_fetch
    import leb128_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MEM_DEPTH:0]          pc,
    input  logic                        is_signed,
    input  logic                        is_64,
    output logic                        busy,
    output logic                        done,
    output logic [63:0]                 value,
    output logic [1:0]                  value_type,
    output logic [3:0]                  length,
    output logic [MEM_DEPTH:0]          next_pc,
    output logic [3:0]                  trap,
    output logic [MEM_DEPTH:0]          mem_addr,
    output logic [MEM_EXTRA-1:0]        mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0] mem_data,
    input  logic                        mem_error
);

    localparam int AW = MEM_DEPTH + 1;
    localparam int DW = (2**MEM_EXTRA) * 8;

    state_t              state_r;
    logic [AW-1:0]       pc_r;
    logic                signed_r;
    logic                wide_r;
    logic [WIN_BITS-1:0] window_r;
    logic                err_r;
    logic [3:0]          idx_r;
    logic [63:0]         acc_r;

    logic                busy_r;
    logic                done_r;
    logic [63:0]         value_r;
    logic [1:0]          value_type_r;
    logic [3:0]          length_r;
    logic [AW-1:0]       next_pc_r;
    logic [3:0]          trap_r;
    logic [AW-1:0]       mem_addr_r;
    logic [MEM_EXTRA-1:0] mem_extra_r;

    logic [7:0]          byte_s;
    logic [6:0]          shamt_s;
    logic [63:0]         acc_next_s;
    logic [3:0]          len_next_s;
    logic [3:0]          limit_s;
    logic                last_s;
    logic [63:0]         fill_s;
    logic [63:0]         ext_s;
    logic [AW-1:0]       next_pc_s;
    logic                fin_s;
    logic [3:0]          fin_trap_s;
    logic [3:0]          fin_len_s;
    logic [63:0]         fin_value_s;
    logic [AW-1:0]       fin_next_pc_s;

    // ROM bytes beyond the longest encoding are never looked at.
    logic                unused_data_s;
    assign unused_data_s = ^mem_data[DW-1:WIN_BITS];

    assign busy       = busy_r;
    assign done       = done_r;
    assign value      = value_r;
    assign value_type = value_type_r;
    assign length     = length_r;
    assign next_pc    = next_pc_r;
    assign trap       = trap_r;
    assign mem_addr   = mem_addr_r;
    assign mem_extra  = mem_extra_r;

    // Per-byte decode step: accumulate payload, detect end, overlong and padding errors.
    always_comb begin
        byte_s        = window_r[7:0];
        shamt_s       = 7'(idx_r) * 7'd7;
        acc_next_s    = acc_r | ({57'd0, byte_s[6:0]} << shamt_s);
        len_next_s    = idx_r + 4'd1;
        limit_s       = wide_r ? 4'd10 : 4'd5;
        last_s        = (len_next_s == limit_s);
        fill_s        = (signed_r && byte_s[6] && (len_next_s < 4'd10))
                        ? sign_fill_mask(len_next_s) : 64'd0;
        ext_s         = acc_next_s | fill_s;
        next_pc_s     = pc_r + AW'(len_next_s);

        fin_s         = 1'b0;
        fin_trap_s    = TRAP_NONE;
        fin_len_s     = 4'd0;
        fin_value_s   = 64'd0;
        fin_next_pc_s = pc_r;
        if (err_r) begin
            fin_s         = 1'b1;
            fin_trap_s    = TRAP_MEM_BOUNDS;
        end else if (byte_s[7] && last_s) begin
            fin_s         = 1'b1;
            fin_trap_s    = TRAP_LEB_OVERLONG;
            fin_len_s     = len_next_s;
            fin_next_pc_s = next_pc_s;
        end else if (byte_s[7]) begin
            fin_s         = 1'b0;
        end else if (last_s && !pad_ok(byte_s[6:0], wide_r, signed_r)) begin
            fin_s         = 1'b1;
            fin_trap_s    = TRAP_LEB_PADDING;
            fin_len_s     = len_next_s;
            fin_next_pc_s = next_pc_s;
        end else begin
            fin_s         = 1'b1;
            fin_len_s     = len_next_s;
            fin_value_s   = wide_r ? ext_s : {32'd0, ext_s[31:0]};
            fin_next_pc_s = next_pc_s;
        end
    end

    // Request FSM with datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= '0;
            signed_r     <= 1'b0;
            wide_r       <= 1'b0;
            window_r     <= '0;
            err_r        <= 1'b0;
            idx_r        <= 4'd0;
            acc_r        <= 64'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            value_r      <= 64'd0;
            value_type_r <= TYPE_I32;
            length_r     <= 4'd0;
            next_pc_r    <= '0;
            trap_r       <= TRAP_NONE;
            mem_addr_r   <= '0;
            mem_extra_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_FETCH;
                        pc_r        <= pc;
                        signed_r    <= is_signed;
                        wide_r      <= is_64;
                        busy_r      <= 1'b1;
                        mem_addr_r  <= pc;
                        mem_extra_r <= is_64 ? MEM_EXTRA'(4'd9) : MEM_EXTRA'(4'd4);
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    window_r <= mem_data[WIN_BITS-1:0];
                    err_r    <= mem_error;
                    idx_r    <= 4'd0;
                    acc_r    <= 64'd0;
                    state_r  <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (fin_s) begin
                        state_r      <= ST_DONE;
                        done_r       <= 1'b1;
                        value_r      <= fin_value_s;
                        value_type_r <= wide_r ? TYPE_I64 : TYPE_I32;
                        length_r     <= fin_len_s;
                        next_pc_r    <= fin_next_pc_s;
                        trap_r       <= fin_trap_s;
                    end else begin
                        acc_r    <= acc_next_s;
                        idx_r    <= len_next_s;
                        window_r <= {8'd0, window_r[WIN_BITS-1:8]};
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_fetch.sv
// Directed self-checking bench for leb128_fetch with a small combinational ROM model.
module tb_leb128_fetch;
    import leb128_fetch_pkg::*;

    localparam int ROM_UPPER = 100;

    logic         clk;
    logic         reset;
    logic         start;
    logic [6:0]   pc;
    logic         is_signed;
    logic         is_64;
    logic         busy;
    logic         done;
    logic [63:0]  value;
    logic [1:0]   value_type;
    logic [3:0]   length;
    logic [6:0]   next_pc;
    logic [3:0]   trap;
    logic [6:0]   mem_addr;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data;
    logic         mem_error;

    logic [7:0]   rom [128];
    int           n_cmp;
    int           n_fail;

    leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc),
        .is_signed(is_signed), .is_64(is_64), .busy(busy), .done(done),
        .value(value), .value_type(value_type), .length(length),
        .next_pc(next_pc), .trap(trap), .mem_addr(mem_addr),
        .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: little-endian window at mem_addr, error above the upper bound.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            mem_data[i*8 +: 8] = rom[mem_addr + 7'(i)];
        end
        mem_error = (int'(mem_addr) > ROM_UPPER);
    end

    task automatic load(input logic [6:0] addr, input logic [7:0] b [$]);
        for (int i = 0; i < b.size(); i++) rom[addr + 7'(i)] = b[i];
    endtask

    // Drives one request, returns the edges from acceptance to done, and checks
    // busy during done and the single-cycle done pulse.
    task automatic run(input logic [6:0] p, input logic s, input logic w,
                       input bit poke, output int cyc);
        @(negedge clk);
        start = 1'b1; pc = p; is_signed = s; is_64 = w;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", busy); end
        if (poke) begin start = 1'b1; pc = 7'd40; is_signed = ~s; is_64 = ~w; end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: got %b want 1", done); end
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_done: got %b want 1", busy); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_busy_fall: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        n_cmp++;
        if (value !== 64'd0 || length !== 4'd0 || next_pc !== 7'd0 || trap !== 4'd0) begin
            n_fail++; $display("FAIL reset_result: got v=%h l=%0d np=%0d t=%0d want 0", value, length, next_pc, trap);
        end
        n_cmp++;
        if (mem_addr !== 7'd0 || mem_extra !== 4'd0 || value_type !== TYPE_I32) begin
            n_fail++; $display("FAIL reset_mem: got a=%0d e=%0d vt=%0d want 0 0 %0d", mem_addr, mem_extra, value_type, TYPE_I32);
        end
    endtask

    task automatic test_unsigned32(input bit poke);
        int cyc;
        load(7'd17, '{8'hE5, 8'h8E, 8'h26});
        run(7'd17, 1'b0, 1'b0, poke, cyc);
        n_cmp++;
        if (value !== 64'd624485) begin n_fail++; $display("FAIL u32_value: got %0d want 624485", value); end
        n_cmp++;
        if (length !== 4'd3 || next_pc !== 7'd20) begin
            n_fail++; $display("FAIL u32_len: got l=%0d np=%0d want 3 20", length, next_pc);
        end
        n_cmp++;
        if (trap !== TRAP_NONE || value_type !== TYPE_I32) begin
            n_fail++; $display("FAIL u32_trap_type: got t=%0d vt=%0d want 0 %0d", trap, value_type, TYPE_I32);
        end
        n_cmp++;
        if (cyc != 5) begin n_fail++; $display("FAIL u32_latency: got %0d want 5", cyc); end
        n_cmp++;
        if (mem_addr !== 7'd17 || mem_extra !== 4'd4) begin
            n_fail++; $display("FAIL u32_mem: got a=%0d e=%0d want 17 4", mem_addr, mem_extra);
        end
    endtask

    task automatic test_signed64();
        int cyc;
        load(7'd40, '{8'hC0, 8'hBB, 8'h78});
        run(7'd40, 1'b1, 1'b1, 1'b0, cyc);
        n_cmp++;
        if (value !== 64'hFFFF_FFFF_FFFE_1DC0) begin
            n_fail++; $display("FAIL s64_value: got %h want fffffffffffe1dc0", value);
        end
        n_cmp++;
        if (value_type !== TYPE_I64 || length !== 4'd3 || next_pc !== 7'd43) begin
            n_fail++; $display("FAIL s64_meta: got vt=%0d l=%0d np=%0d want %0d 3 43", value_type, length, next_pc, TYPE_I64);
        end
        n_cmp++;
        if (mem_extra !== 4'd9) begin n_fail++; $display("FAIL s64_extra: got %0d want 9", mem_extra); end
    endtask

    task automatic test_signed32_one_byte();
        int cyc;
        load(7'd60, '{8'h7F});
        run(7'd60, 1'b1, 1'b0, 1'b0, cyc);
        n_cmp++;
        if (value !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++; $display("FAIL s32_value: got %h want 00000000ffffffff", value);
        end
        n_cmp++;
        if (length !== 4'd1 || next_pc !== 7'd61 || cyc != 3) begin
            n_fail++; $display("FAIL s32_meta: got l=%0d np=%0d cyc=%0d want 1 61 3", length, next_pc, cyc);
        end
    endtask

    task automatic test_max_length();
        int cyc;
        load(7'd0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F});
        run(7'd0, 1'b0, 1'b0, 1'b0, cyc);
        n_cmp++;
        if (value !== 64'h0000_0000_FFFF_FFFF || length !== 4'd5 || trap !== TRAP_NONE || cyc != 7) begin
            n_fail++; $display("FAIL u32_max: got v=%h l=%0d t=%0d cyc=%0d want ffffffff 5 0 7", value, length, trap, cyc);
        end
        load(7'd0, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F});
        run(7'd0, 1'b1, 1'b1, 1'b0, cyc);
        n_cmp++;
        if (value !== 64'h8000_0000_0000_0000 || length !== 4'd10 || trap !== TRAP_NONE || next_pc !== 7'd10) begin
            n_fail++; $display("FAIL s64_min: got v=%h l=%0d t=%0d np=%0d want 8000000000000000 10 0 10", value, length, trap, next_pc);
        end
    endtask

    task automatic test_malformed();
        int cyc;
        load(7'd70, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00});
        run(7'd70, 1'b0, 1'b0, 1'b0, cyc);
        n_cmp++;
        if (trap !== TRAP_LEB_OVERLONG || length !== 4'd5 || value !== 64'd0 || next_pc !== 7'd75) begin
            n_fail++; $display("FAIL overlong: got t=%0d l=%0d v=%h np=%0d want %0d 5 0 75", trap, length, value, next_pc, TRAP_LEB_OVERLONG);
        end
        load(7'd80, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F});
        run(7'd80, 1'b0, 1'b0, 1'b0, cyc);
        n_cmp++;
        if (trap !== TRAP_LEB_PADDING || length !== 4'd5 || value !== 64'd0) begin
            n_fail++; $display("FAIL padding: got t=%0d l=%0d v=%h want %0d 5 0", trap, length, value, TRAP_LEB_PADDING);
        end
    endtask

    task automatic test_mem_bounds();
        int cyc;
        run(7'd110, 1'b0, 1'b1, 1'b0, cyc);
        n_cmp++;
        if (trap !== TRAP_MEM_BOUNDS || length !== 4'd0 || value !== 64'd0 || next_pc !== 7'd110) begin
            n_fail++; $display("FAIL mem_bounds: got t=%0d l=%0d v=%h np=%0d want %0d 0 0 110", trap, length, value, next_pc, TRAP_MEM_BOUNDS);
        end
        n_cmp++;
        if (cyc != 3) begin n_fail++; $display("FAIL mem_latency: got %0d want 3", cyc); end
    endtask

    task automatic test_reset_mid_decode();
        bit saw_done;
        load(7'd17, '{8'hE5, 8'h8E, 8'h26});
        @(negedge clk);
        start = 1'b1; pc = 7'd17; is_signed = 1'b0; is_64 = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || value !== 64'd0 || trap !== 4'd0 ||
            length !== 4'd0 || next_pc !== 7'd0 || mem_addr !== 7'd0 || mem_extra !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b done=%b v=%h l=%0d a=%0d want all 0", busy, done, value, length, mem_addr);
        end
        saw_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
        n_cmp++;
        if (saw_done) begin n_fail++; $display("FAIL mid_reset_no_done: got done pulse want none"); end
        test_unsigned32(1'b0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0; start = 1'b0; pc = 7'd0; is_signed = 1'b0; is_64 = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_unsigned32(1'b0);
        test_signed64();
        test_signed32_one_byte();
        test_max_length();
        test_malformed();
        test_mem_bounds();
        test_unsigned32(1'b1);
        test_reset_mid_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
